// File: rtl/mult_arbiter_if.sv
// Bus bundle for mult_arbiter: requester handshake, result reporting and the
// control/data path to the shared shift-add multiplier core.
// The arbiter connects through the slave modport; the requesters and the
// multiplier core together drive the master side.
interface mult_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]   req;
    logic [R*N-1:0] a_in;
    logic [R*N-1:0] b_in;
    logic [R-1:0]   gnt;
    logic           done;
    logic [RW-1:0]  done_id;
    logic [2*N-1:0] product;
    logic           busy;
    logic           err;
    logic [2*N-1:0] mul_a;
    logic [2*N-1:0] mul_b;
    logic           mul_start;
    logic           mul_finish;
    logic [2*N-1:0] mul_out;

    modport slave (
        input  req, a_in, b_in, mul_finish, mul_out,
        output gnt, done, done_id, product, busy, err, mul_a, mul_b, mul_start
    );

    modport master (
        output req, a_in, b_in, mul_finish, mul_out,
        input  gnt, done, done_id, product, busy, err, mul_a, mul_b, mul_start
    );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one shift-add multiplier core among
// R requesters. One operation runs at a time: IDLE (grant) -> LOAD (core loads
// operands) -> RUN (core iterates until mul_finish) -> DONE (result pulse).
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort RUN after N+4 cycles
// without mul_finish, reporting product=0 with err=1. Without it, err is tied
// low and RUN waits for the core indefinitely.
module mult_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic          clk,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    localparam int RW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(N + 5);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  ptr_q, ptr_d;
    logic [RW-1:0]  cur_id_q, cur_id_d;
    logic [RW-1:0]  done_id_q, done_id_d;
    logic [2*N-1:0] product_q, product_d;
    logic [2*N-1:0] mul_a_q, mul_a_d;
    logic [2*N-1:0] mul_b_q, mul_b_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           any_req;
    logic [RW-1:0]  win_idx;
    logic [RW:0]    cand_sum;
    logic [RW-1:0]  cand;
    logic [N-1:0]   win_a;
    logic [N-1:0]   win_b;
    logic [R-1:0]   gnt_c;

`ifdef MULT_ARB_TIMEOUT_EN
    // Last RUN cycle count value before the counter would reach N+4.
    localparam logic [CW-1:0] TMO_LAST = CW'(N + 3);
    logic err_q, err_d;
`endif

    // Round-robin search: walk from ptr upwards with wrap, first set bit wins.
    always_comb begin
        any_req  = 1'b0;
        win_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < R; i++) begin
            cand_sum = {1'b0, ptr_q} + (RW+1)'(i);
            if (cand_sum >= (RW+1)'(R)) begin
                cand_sum = cand_sum - (RW+1)'(R);
            end
            cand = cand_sum[RW-1:0];
            if (!any_req && bus.req[cand]) begin
                any_req = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Operand mux selecting the winning requester's a/b slices.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < R; k++) begin
            if (win_idx == RW'(k)) begin
                win_a = bus.a_in[k*N +: N];
                win_b = bus.b_in[k*N +: N];
            end
        end
    end

    // Next-state and datapath update for the IDLE/LOAD/RUN/DONE sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_id_d  = cur_id_q;
        done_id_d = done_id_q;
        product_d = product_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        cnt_d     = cnt_q;
        gnt_c     = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_c[win_idx] = 1'b1;
                    cur_id_d       = win_idx;
                    mul_a_d        = {{N{1'b0}}, win_a};
                    mul_b_d        = {{N{1'b0}}, win_b};
                    ptr_d          = (win_idx == RW'(R - 1)) ? '0 : win_idx + 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mul_finish) begin
                    product_d = bus.mul_out;
                    done_id_d = cur_id_q;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    product_d = '0;
                    done_id_d = cur_id_q;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cur_id_q  <= '0;
            done_id_q <= '0;
            product_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            cnt_q     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_id_q  <= cur_id_d;
            done_id_q <= done_id_d;
            product_q <= product_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            cnt_q     <= cnt_d;
`ifdef MULT_ARB_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

    // Grant is combinational in IDLE; held quiet while reset is asserted.
    assign bus.gnt       = reset ? gnt_c : '0;
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.mul_start = (state_q == RUN);
    assign bus.done_id   = done_id_q;
    assign bus.product   = product_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed testbench for mult_arbiter (N=8, R=4) with a behavioural
// shift-add core model that raises mul_finish after N iterations.
module tb_mult_arbiter;
    localparam int N  = 8;
    localparam int R  = 4;
    localparam int IW = $clog2(R * N);

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic core_en;
    int   core_cnt = 0;
    logic core_fin = 1'b0;

    int   order [5] = '{0, 1, 2, 3, 0};
    int   prods [5] = '{6, 12, 20, 30, 6};

    mult_arbiter_if #(.N(N), .R(R)) bus ();

    mult_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: reloads while mul_start=0, finishes after N iterations.
    always @(posedge clk) begin
        if (!bus.mul_start) begin
            core_cnt <= 0;
            core_fin <= 1'b0;
        end else if (core_cnt < N) begin
            core_cnt <= core_cnt + 1;
            core_fin <= core_en && (core_cnt == N - 1);
        end
    end

    assign bus.mul_finish = core_fin;
    assign bus.mul_out    = bus.mul_a * bus.mul_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_done(input int limit, output int c);
        c = -1;
        for (int t = 0; t <= limit; t++) begin
            if (bus.done) begin
                c = cyc;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_gnt(input int limit, output logic [R-1:0] g, output int c);
        c = -1;
        g = '0;
        for (int t = 0; t <= limit; t++) begin
            if (bus.gnt != '0) begin
                c = cyc;
                g = bus.gnt;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic set_ops(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.a_in[IW'(k*N) +: N] = a;
        bus.b_in[IW'(k*N) +: N] = b;
    endtask

    task automatic run_one(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int exp_p, input int exp_lat);
        int g_cyc;
        int d_cyc;
        @(negedge clk);
        bus.req = R'(1) << k;
        set_ops(k, a, b);
        #1;
        check("gnt", 32'(bus.gnt), 32'd1 << k);
        g_cyc = cyc;
        @(negedge clk);
        bus.req  = '0;
        bus.a_in = '1;
        bus.b_in = '1;
        #1;
        check("load_start", 32'(bus.mul_start), 32'd0);
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_a", 32'(bus.mul_a), 32'(a));
        @(negedge clk); #1;
        check("run_start", 32'(bus.mul_start), 32'd1);
        check("run_b", 32'(bus.mul_b), 32'(b));
        wait_done(30, d_cyc);
        check("latency", d_cyc - g_cyc, exp_lat);
        check("product", 32'(bus.product), exp_p);
        check("done_id", 32'(bus.done_id), k);
        check("err", 32'(bus.err), 32'd0);
        @(negedge clk); #1;
        check("held", 32'(bus.product), exp_p);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [R-1:0] g;
        int gc;
        int dc;
        int prev;
        int hold;

        reset    = 1'b0;
        core_en  = 1'b1;
        bus.req  = 4'hF;
        bus.a_in = '0;
        bus.b_in = '0;
        @(negedge clk); #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_mul_a", 32'(bus.mul_a), 32'd0);
        check("rst_mul_b", 32'(bus.mul_b), 32'd0);
        check("rst_start", 32'(bus.mul_start), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_done_id", 32'(bus.done_id), 32'd0);

        @(negedge clk);
        bus.req = '0;
        reset   = 1'b1;

        // Single operations: basic, maximum and zero operands.
        run_one(0, 8'd12, 8'd13, 156, 11);
        run_one(1, 8'd255, 8'd255, 65025, 11);
        run_one(3, 8'd0, 8'd200, 0, 11);

        // Continuous contention from reset release.
        @(negedge clk);
        reset    = 1'b0;
        bus.req  = 4'hF;
        bus.a_in = {8'd5, 8'd4, 8'd3, 8'd2};
        bus.b_in = {8'd6, 8'd5, 8'd4, 8'd3};
        @(negedge clk);
        reset = 1'b1;
        #1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(20, g, gc);
            check("rr_gnt", 32'(g), 32'd1 << order[i]);
            wait_done(20, dc);
            check("rr_id", 32'(bus.done_id), order[i]);
            check("rr_prod", 32'(bus.product), prods[i]);
            if (i > 0) check("rr_space", dc - prev, 12);
            prev = dc;
        end

        // Request withdrawn before the grant edge is not granted.
        @(negedge clk);
        bus.req = '0;
        #1;
        check("drop_gnt", 32'(bus.gnt), 32'd0);
        @(negedge clk); #1;
        check("drop_busy", 32'(bus.busy), 32'd0);

        // Reset in RUN cycle 4 aborts the operation.
        @(negedge clk);
        bus.req = 4'b0010;
        #1;
        check("abort_gnt", 32'(bus.gnt), 32'd2);
        @(negedge clk);
        bus.req = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_start", 32'(bus.mul_start), 32'd0);
        check("abort_prod", 32'(bus.product), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 4'b0100;
        set_ops(2, 8'd7, 8'd9);
        #1;
        check("rel_gnt", 32'(bus.gnt), 32'd4);
        check("rel_done", 32'(bus.done), 32'd0);
        gc = cyc;
        @(negedge clk);
        bus.req = '0;
        #1;
        wait_done(20, dc);
        check("rel_lat", dc - gc, 11);
        check("rel_prod", 32'(bus.product), 32'd63);
        check("rel_id", 32'(bus.done_id), 32'd2);

        // Core never finishes; pointer must also restart at 0 after reset.
        @(negedge clk);
        core_en = 1'b0;
        reset   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 4'b1010;
        set_ops(1, 8'd10, 8'd10);
        #1;
        check("ptr_rst_gnt", 32'(bus.gnt), 32'd2);
        gc = cyc;
        @(negedge clk);
        bus.req = '0;
        #1;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_done(30, dc);
        check("tmo_lat", dc - gc, 14);
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_prod", 32'(bus.product), 32'd0);
        check("tmo_id", 32'(bus.done_id), 32'd1);
`else
        hold = 0;
        repeat (30) begin
            if (bus.busy && !bus.done) hold++;
            @(negedge clk); #1;
        end
        check("no_tmo_busy", hold, 30);
`endif
        reset = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 8: operand width in bits of the shared shift-add multiplier.
REQ-002 Parameter R, default 4: number of requesters; RW = clog2(R), minimum 1.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req  input  R  per-requester request level, held until gnt.
REQ-006 a_in  input  R*N  requester k multiplicand at bits [k*N +: N].
REQ-007 b_in  input  R*N  requester k multiplier at bits [k*N +: N].
REQ-008 gnt  output  R  one-hot one-cycle grant pulse; operands latched on the same edge.
REQ-009 done  output  1  one-cycle pulse; product and done_id are valid.
REQ-010 done_id  output  RW  index of the requester whose result is on product.
REQ-011 product  output  2N  result, held until the next done.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  timeout flag, valid with done.
REQ-014 mul_a, mul_b  output  2N each  operands to the multiplier core, zero-extended.
REQ-015 mul_start  output  1  core control: 0 = load operands, 1 = iterate.
REQ-016 mul_finish  input  1  core completion flag.
REQ-017 mul_out  input  2N  core product.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN and DONE, encoded in 2 bits.
REQ-019 IDLE, with any req bit set: grant one requester, latch its operands into mul_a and mul_b, and go to LOAD.
REQ-020 IDLE, with no req bit set: stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: search starts at pointer ptr, wraps from R-1 to 0, and the first set bit wins.
REQ-022 After each grant, ptr SHALL become (granted index + 1) mod R.
REQ-023 LOAD SHALL last exactly 1 cycle with mul_start=0, then go to RUN.
REQ-024 In RUN, mul_start SHALL be 1 and a cycle counter SHALL increment every RUN cycle.
REQ-025 RUN, on an edge where mul_finish=1 is sampled: capture mul_out into product, set done_id, clear err, and go to DONE.
REQ-026 DONE SHALL last exactly 1 cycle with done=1, drive mul_start=0, issue no grant, then go to IDLE.
REQ-027 Latency with a nominal core (finish after N iterations): done SHALL be high in cycle G+N+3, where G is the gnt cycle.
REQ-028 Throughput SHALL be one operation per N+4 cycles when requests are continuous.
REQ-029 A req deasserted before its grant SHALL NOT be granted; no error is raised.
REQ-030 A req still high during DONE SHALL be treated as a new request in the following IDLE cycle.
REQ-031 Requests changing while busy SHALL NOT affect the latched operands.
REQ-032 mul_start SHALL be 0 in IDLE, LOAD and DONE.
REQ-033 gnt SHALL be 0 outside the IDLE grant cycle.

Reset
REQ-034 When reset is low: state=IDLE and ptr=0.
REQ-035 When reset is low, these outputs SHALL be 0: gnt, done, done_id, product, busy, err, mul_a, mul_b, mul_start.
REQ-036 Reset asserted mid-operation SHALL abort the operation with no done pulse; the aborted requester must re-request.
REQ-037 Reset deassertion SHALL take effect at the first rising clk edge after reset goes high.

Configuration
REQ-038 With macro MULT_ARB_TIMEOUT_EN defined, RUN SHALL abort when the counter reaches N+4 without mul_finish.
REQ-039 On that timeout: go to DONE with product=0 and err=1, and pulse done for the timed-out requester.
REQ-040 With MULT_ARB_TIMEOUT_EN undefined: no timeout logic, err tied 0, and RUN waits indefinitely for mul_finish.

Verification
REQ-041 Single request: N=8, req=0001, a=12, b=13 -> gnt=0001 in cycle G; done in cycle G+11 with product=156, done_id=0, err=0.
REQ-042 Contention: req=1111 held from reset release -> grants in order 0,1,2,3,0; the done spacing is 12 cycles.
REQ-043 Maximum operands: a=255, b=255 -> product=65025.
REQ-044 Zero operands: a=0, b=200 -> product=0, with unchanged latency.
REQ-045 Reset mid-operation: reset pulsed low in RUN cycle 4 -> no done; busy=0; ptr=0; next req=0100 is granted immediately after release.
REQ-046 Timeout with MULT_ARB_TIMEOUT_EN defined and mul_finish tied 0 -> done with err=1 and product=0 in cycle G+14; without the macro, busy stays 1.
